// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the multi-width SPRAM adapter.
package mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} sz_t;

  typedef enum logic {IDLE, HI} state_t;

  // Byte-lane mask over two adjacent words: bits [3:0] low word, [6:4] high word.
  function automatic logic [6:0] lane_mask(input sz_t sz, input logic [1:0] off);
    logic [6:0] base;
    case (sz)
      SZ_B:    base = 7'b000_0001;
      SZ_H:    base = 7'b000_0011;
      SZ_W:    base = 7'b000_1111;
      default: base = '0;
    endcase
    return base << off;
  endfunction

  // Pulls an LSB-justified, zero-extended value out of a {high, low} word pair.
  function automatic logic [31:0] byte_extract(input logic [63:0] word, input logic [1:0] off,
                                               input sz_t sz);
    logic [31:0] s;
    s = 32'(word >> {off, 3'b000});
    case (sz)
      SZ_B:    return {24'h0, s[7:0]};
      SZ_H:    return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/spram32_bank.sv
// DEPTH_W x 32 single-port bank: per-byte write mask, registered read.
// Written as a plain array so iCE40 flows map it onto cascaded SB_SPRAM256KA blocks.
module spram32_bank #(
  parameter int unsigned DEPTH_W = 32768
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [$clog2(DEPTH_W)-1:0] addr,
  input  logic [3:0]                 be,
  input  logic [31:0]                wd,
  output logic [31:0]                rd
);

  logic [31:0] mem [DEPTH_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
        end
      end else begin
        rd <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spram32_mw.sv
// Byte/half/word adapter over spram32_bank; little-endian lanes.
// SPRAM_MISALIGN_EN enables split servicing of word-crossing accesses (else rejected).
module spram32_mw
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_W = 32768,
  parameter int unsigned AW      = $clog2(DEPTH_W) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          rdy,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] ai,
  input  logic [31:0]   vi,
  output logic [31:0]   vo,
  output logic          vld,
  output logic          err
);

  localparam int unsigned WA = AW - 2;

  logic [1:0]    off;
  sz_t           size;
  logic [6:0]    m;
  logic [55:0]   d;
  logic [WA-1:0] widx;
  logic          split;
  logic          illegal;
  logic          accept;
  logic          reject;

  logic          bank_en;
  logic          bank_we;
  logic [WA-1:0] bank_addr;
  logic [3:0]    bank_be;
  logic [31:0]   bank_wd;
  logic [31:0]   bank_rd;

  logic          rd_vld;
  logic [1:0]    rd_off;
  sz_t           rd_sz;
  logic [31:0]   vo_hold;
  logic [63:0]   vo_word;

  assign off     = ai[1:0];
  assign size    = sz_t'(sz);
  assign widx    = ai[AW-1:2];
  assign m       = lane_mask(size, off);
  assign d       = {24'h0, vi} << {off, 3'b000};
  assign split   = |m[6:4];
  assign illegal = (size == SZ_X);
  assign accept  = req && rdy;
  assign vld     = rd_vld;

`ifdef SPRAM_MISALIGN_EN
  state_t        state;
  logic          hi_we;
  logic [WA-1:0] hi_addr;
  logic [2:0]    hi_m;
  logic [23:0]   hi_d;
  logic [31:0]   lo_word;
  logic          rd_split;

  assign rdy    = !rst && (state == IDLE);
  assign reject = illegal;
`else
  logic unused_hi_d;

  assign unused_hi_d = ^d[55:32];
  assign rdy         = !rst;
  assign reject      = illegal || split;
`endif

  always_comb begin
    bank_en   = accept && !reject;
    bank_we   = we;
    bank_addr = widx;
    bank_be   = m[3:0];
    bank_wd   = d[31:0];
`ifdef SPRAM_MISALIGN_EN
    if (state == HI) begin
      bank_en   = 1'b1;
      bank_we   = hi_we;
      bank_addr = hi_addr;
      bank_be   = {1'b0, hi_m};
      bank_wd   = {8'h00, hi_d};
    end
`endif
  end

  spram32_bank #(
    .DEPTH_W(DEPTH_W)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (bank_we),
    .addr (bank_addr),
    .be   (bank_be),
    .wd   (bank_wd),
    .rd   (bank_rd)
  );

  // Split reads merge the held low word with the high word arriving this cycle.
  always_comb begin
`ifdef SPRAM_MISALIGN_EN
    vo_word = rd_split ? {bank_rd, lo_word} : {32'h0, bank_rd};
`else
    vo_word = {32'h0, bank_rd};
`endif
    vo = rd_vld ? byte_extract(vo_word, rd_off, rd_sz) : vo_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      err      <= 1'b0;
      rd_off   <= '0;
      rd_sz    <= SZ_B;
      vo_hold  <= '0;
`ifdef SPRAM_MISALIGN_EN
      state    <= IDLE;
      hi_we    <= 1'b0;
      hi_addr  <= '0;
      hi_m     <= '0;
      hi_d     <= '0;
      lo_word  <= '0;
      rd_split <= 1'b0;
`endif
    end else begin
      err    <= accept && reject;
      rd_vld <= 1'b0;
      if (rd_vld) vo_hold <= vo;
      if (accept && !reject && !we) begin
        rd_off <= off;
        rd_sz  <= size;
        rd_vld <= !split;
`ifdef SPRAM_MISALIGN_EN
        rd_split <= split;
`endif
      end
`ifdef SPRAM_MISALIGN_EN
      case (state)
        IDLE: begin
          if (accept && !reject && split) begin
            state   <= HI;
            hi_we   <= we;
            hi_addr <= widx + 1'b1;
            hi_m    <= m[6:4];
            hi_d    <= d[55:32];
          end
        end
        HI: begin
          state   <= IDLE;
          lo_word <= bank_rd;
          rd_vld  <= !hi_we;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_spram32_mw.sv
// Self-checking bench for spram32_mw (DEPTH_W=256) against a byte-array model.
module tb_spram32_mw;

  localparam int DEPTH_W = 256;
  localparam int AW      = 10;
  localparam int NBYTES  = DEPTH_W * 4;
`ifdef SPRAM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req;
  logic          rdy;
  logic          we;
  logic [1:0]    sz;
  logic [AW-1:0] ai;
  logic [31:0]   vi;
  logic [31:0]   vo;
  logic          vld;
  logic          err;

  spram32_mw #(
    .DEPTH_W(DEPTH_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .rdy (rdy),
    .we  (we),
    .sz  (sz),
    .ai  (ai),
    .vi  (vi),
    .vo  (vo),
    .vld (vld),
    .err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [NBYTES];
  bit          busy = 1'b0;
  bit          ev = 1'b0;
  bit          ee = 1'b0;
  logic [31:0] evo = '0;
  bit          p_we;
  int          p_a;
  int          p_n;
  logic [31:0] p_v;

  // part: 0 = bytes in the first word, 1 = bytes spilling into the next word, 2 = all
  task automatic mwrite(input int a, input int n, input logic [31:0] v, input int part);
    for (int i = 0; i < n; i++) begin
      bit hi;
      hi = ((a % 4) + i) >= 4;
      if (part == 2 || (part == 1 && hi) || (part == 0 && !hi))
        mm[(a + i) % NBYTES] = v[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] mread(input int a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mm[(a + i) % NBYTES];
    return r;
  endfunction

  always @(posedge clk) begin
    int n;
    int o;
    bit spl;
    if (rst) begin
      busy = 1'b0;
      ev   = 1'b0;
      ee   = 1'b0;
      evo  = '0;
    end else begin
      ev = 1'b0;
      ee = 1'b0;
      if (busy) begin
        busy = 1'b0;
        if (p_we) mwrite(p_a, p_n, p_v, 1);
        else begin
          ev  = 1'b1;
          evo = mread(p_a, p_n);
        end
      end else if (req) begin
        n   = 1 << int'(sz);
        o   = int'(ai) % 4;
        spl = (o + n) > 4;
        if (sz == 2'd3 || (spl && !MIS)) ee = 1'b1;
        else if (spl) begin
          busy = 1'b1;
          p_we = we;
          p_a  = int'(ai);
          p_n  = n;
          p_v  = vi;
          if (we) mwrite(int'(ai), n, vi, 0);
        end else if (we) mwrite(int'(ai), n, vi, 2);
        else begin
          ev  = 1'b1;
          evo = mread(int'(ai), n);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] got[$];
  int          err_seen = 0;

  always @(posedge clk) begin
    #1;
    chk("rdy", {31'h0, rdy}, {31'h0, (!rst && !busy)});
    chk("vld", {31'h0, vld}, {31'h0, ev});
    chk("err", {31'h0, err}, {31'h0, ee});
    chk("vo", vo, evo);
    if (vld) got.push_back(vo);
    if (err) err_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic w, input logic [1:0] s, input int a, input logic [31:0] v);
    req = 1'b1;
    we  = w;
    sz  = s;
    ai  = AW'(a);
    vi  = v;
    @(negedge clk);
    req = 1'b0;
    while (busy) begin
      req = 1'($urandom);
      we  = 1'($urandom);
      ai  = AW'($urandom);
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    int          e0;
    rst = 1'b1;
    req = 1'b0;
    we  = 1'b0;
    sz  = 2'd0;
    ai  = '0;
    vi  = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'h0, rdy}, 32'h0);
    chk("reset_vo", vo, 32'h0);
    chk("reset_vld", {31'h0, vld}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_rdy", {31'h0, rdy}, 32'h1);

    for (int i = 0; i < DEPTH_W; i++) op(1'b1, 2'd2, i * 4, $urandom);
    idle(2);

    // Word write then back-to-back byte reads
    op(1'b1, 2'd2, 'h100, 32'h11223344);
    got.delete();
    for (int i = 0; i < 4; i++) op(1'b0, 2'd0, 'h100 + i, 32'h0);
    idle(3);
    chk("byte_rd_count", got.size(), 4);
    chk("byte_rd0", (got.size() > 0) ? got[0] : 'x, 32'h44);
    chk("byte_rd1", (got.size() > 1) ? got[1] : 'x, 32'h33);
    chk("byte_rd2", (got.size() > 2) ? got[2] : 'x, 32'h22);
    chk("byte_rd3", (got.size() > 3) ? got[3] : 'x, 32'h11);

    // Half write to upper half, lower half untouched
    saved = {mm['h203], mm['h202], mm['h201], mm['h200]};
    op(1'b1, 2'd1, 'h202, 32'hFFFF_BEEF);
    got.delete();
    op(1'b0, 2'd2, 'h200, 32'h0);
    idle(3);
    chk("half_hi", (got.size() > 0) ? {16'h0, got[0][31:16]} : 'x, 32'hBEEF);
    chk("half_lo", (got.size() > 0) ? {16'h0, got[0][15:0]} : 'x, {16'h0, saved[15:0]});
    chk("model_half", {mm['h203], mm['h202]}, 32'hBEEF);

    // Illegal size: err, no vld
    got.delete();
    e0 = err_seen;
    op(1'b0, 2'd3, 'h40, 32'h0);
    idle(3);
    chk("illegal_err", err_seen - e0, 1);
    chk("illegal_novld", got.size(), 0);

`ifdef SPRAM_MISALIGN_EN
    op(1'b1, 2'd2, 'h103, 32'hAABBCCDD);
    got.delete();
    op(1'b0, 2'd2, 'h103, 32'h0);
    idle(3);
    chk("split_word", (got.size() > 0) ? got[0] : 'x, 32'hAABBCCDD);
    chk("model_split", {mm['h106], mm['h105], mm['h104], mm['h103]}, 32'hAABBCCDD);

    op(1'b1, 2'd1, 'h3FF, 32'h1234);
    chk("model_wrap", {mm[0], mm['h3FF]}, 32'h1234);
    got.delete();
    op(1'b0, 2'd1, 'h3FF, 32'h0);
    op(1'b0, 2'd0, 'h000, 32'h0);
    idle(3);
    chk("wrap_half", (got.size() > 0) ? got[0] : 'x, 32'h1234);
    chk("wrap_byte", (got.size() > 1) ? got[1] : 'x, 32'h12);

    // Reset asserted in the HI cycle of a split write
    saved = {16'h0, mm['h201], mm['h200]};
    req = 1'b1;
    we  = 1'b1;
    sz  = 2'd2;
    ai  = AW'('h1FE);
    vi  = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_hi_rdy", {31'h0, rdy}, 32'h0);
    chk("rst_hi_vld", {31'h0, vld}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("model_rst_lo", {mm['h1FF], mm['h1FE]}, 32'hF00D);
    got.delete();
    op(1'b0, 2'd1, 'h200, 32'h0);
    op(1'b0, 2'd1, 'h1FE, 32'h0);
    idle(3);
    chk("rst_hi_kept", (got.size() > 0) ? got[0] : 'x, saved);
    chk("rst_lo_done", (got.size() > 1) ? got[1] : 'x, 32'hF00D);
`else
    got.delete();
    e0 = err_seen;
    op(1'b0, 2'd2, 'h101, 32'h0);
    op(1'b1, 2'd2, 'h101, 32'h5A5A5A5A);
    idle(3);
    chk("misalign_err", err_seen - e0, 2);
    chk("misalign_novld", got.size(), 0);
    op(1'b0, 2'd2, 'h100, 32'h0);
    op(1'b0, 2'd2, 'h104, 32'h0);
    idle(3);
    chk("misalign_unchanged", (got.size() > 0) ? got[0] : 'x, 32'h11223344);
`endif

    // Randomised mix
    for (int k = 0; k < 2000; k++) begin
      int          s;
      int          a;
      logic [1:0]  z;
      s = $urandom_range(0, 15);
      z = (s == 0) ? 2'd3 : 2'(s % 3);
      a = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 1) == 1 && z != 2'd3) a = a & ~((1 << int'(z)) - 1);
      op(1'($urandom), z, a, $urandom);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
